dt_arbiter: RTL and testbench
=============================

DT_ARBITER -- requirements
Module: dt_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of timestep requesters (oscillators).
REQ-002 Parameter DT_WIDTH, default 25: width of each timestep request and of emu_dt.
REQ-003 Parameter TIME_WIDTH, default 39: width of emu_time and stop_time.
REQ-004 Parameter DT_MAX, default 2**(DT_WIDTH-1)-1: upper bound on any issued timestep.
REQ-005 emu_clk  in  1  single clock; all state updates occur on the rising edge.
REQ-006 emu_rst  in  1  reset, synchronous and active-high.
REQ-007 run  in  1  level; enables time advance when high.
REQ-008 stall  in  1  level; freezes time advance for the current cycle.
REQ-009 stop_time  in  TIME_WIDTH  unsigned absolute emulated time at which advance terminates.
REQ-010 dt_req  in  N_REQ*DT_WIDTH  packed unsigned requests; slice i is [i*DT_WIDTH +: DT_WIDTH].
REQ-011 emu_dt  out  DT_WIDTH  registered timestep granted for the current cycle.
REQ-012 emu_time  out  TIME_WIDTH  registered accumulated emulated time.
REQ-013 dt_src  out  N_REQ  registered one-hot winner of the current emu_dt; all-zero when no requester won.
REQ-014 state  out  2  FSM state encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-015 step_count  out  32  registered count of cycles with emu_dt > 0.

Function
REQ-016 The FSM SHALL transition IDLE->RUN when run=1, RUN->PAUSE when stall=1 or run=0, PAUSE->RUN when stall=0 and run=1, and RUN/PAUSE->DONE when the next emu_time equals stop_time.
REQ-017 DONE SHALL be absorbing until emu_rst.
REQ-018 The next time SHALL be emu_time_nxt = emu_time + emu_dt; emu_time SHALL load emu_time_nxt on every edge, with a 1-cycle latency from grant to accumulation.
REQ-019 remaining SHALL be defined as stop_time - emu_time_nxt, saturated at 0 when emu_time_nxt >= stop_time.
REQ-020 The candidate dt SHALL be min(dt_req[0..N_REQ-1], DT_MAX, remaining), compared unsigned.
REQ-021 The next state SHALL be computed first; emu_dt SHALL load the candidate only when the next state is RUN, and 0 otherwise.
REQ-022 On equal requests, dt_src SHALL mark the lowest index.
REQ-023 dt_src SHALL be all-zero when DT_MAX or remaining is strictly smaller than every request, and when emu_dt is forced to 0.
REQ-024 A request of 0 SHALL be legal, SHALL win with emu_dt=0, SHALL NOT increment step_count, and SHALL NOT leave RUN.
REQ-025 Clamping by remaining SHALL guarantee that emu_time never exceeds stop_time.
REQ-026 stop_time SHALL be sampled every cycle; if stop_time <= emu_time_nxt while in RUN or PAUSE, the FSM SHALL enter DONE and emu_dt SHALL become 0.
REQ-027 If stall and the DONE condition occur in the same cycle, DONE SHALL take priority.
REQ-028 step_count SHALL wrap modulo 2**32.
REQ-029 emu_time SHALL NOT wrap: the stop_time clamp bounds it.
REQ-030 No combinational path SHALL exist from any input to any output.

Reset
REQ-031 While emu_rst=1 at an edge: state=IDLE, emu_dt=0, emu_time=0, dt_src=0, step_count=0, regardless of other inputs.
REQ-032 Reset asserted mid-RUN SHALL discard the in-flight grant; the first edge after deassertion SHALL evaluate from IDLE.

Verification
REQ-033 Bench: reset; run=1; dt_req={30,20}; stop_time=1000 -> edge 1: emu_dt=20, dt_src=2'b01, state=RUN; edge 2: emu_time=20.
REQ-034 Bench: dt_req={40,40} -> dt_src=2'b01 (lowest index wins on tie).
REQ-035 Bench: dt_req={100,100}; stop_time=250 -> emu_dt sequence 100, 100, 50, 0; emu_time ends at exactly 250; state=DONE; step_count=3.
REQ-036 Bench: stall=1 for 3 cycles mid-RUN -> state=PAUSE, emu_dt=0 for 3 cycles, emu_time frozen; RUN resumes on the edge after stall drops.
REQ-037 Bench: dt_req={0,50} -> emu_dt=0, dt_src=2'b10, step_count unchanged, state stays RUN.
REQ-038 Bench: emu_rst pulsed with emu_time=400 in RUN -> next edge: all outputs 0, state=IDLE.

Source files
------------

// File: rtl/dt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dt_arbiter
// Purpose  : Grants the smallest requested timestep each cycle, clamped so
//            emulated time never passes stop_time.
// Revision : 1.0
// ============================================================================
module dt_arbiter #(
    parameter int          N_REQ      = 2,
    parameter int          DT_WIDTH   = 25,
    parameter int          TIME_WIDTH = 39,
    parameter int unsigned DT_MAX     = 2**(DT_WIDTH-1)-1
) (
    input  logic                      emu_clk,
    input  logic                      emu_rst,
    input  logic                      run,
    input  logic                      stall,
    input  logic [TIME_WIDTH-1:0]     stop_time,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    output logic [DT_WIDTH-1:0]       emu_dt,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic [N_REQ-1:0]          dt_src,
    output logic [1:0]                state,
    output logic [31:0]               step_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [TIME_WIDTH-1:0] c_DT_MAX = TIME_WIDTH'(DT_MAX);

    state_t                r_state;
    logic [DT_WIDTH-1:0]   r_emu_dt;
    logic [TIME_WIDTH-1:0] r_emu_time;
    logic [N_REQ-1:0]      r_dt_src;
    logic [31:0]           r_step_count;

    state_t                w_state_nxt;
    logic [TIME_WIDTH-1:0] w_time_nxt;
    logic [TIME_WIDTH-1:0] w_remaining;
    logic [TIME_WIDTH-1:0] w_limit;
    logic                  w_stop_hit;
    logic [DT_WIDTH-1:0]   w_best_req;
    logic [N_REQ-1:0]      w_best_oh;
    logic                  w_req_wins;
    logic [DT_WIDTH-1:0]   w_cand;
    logic [DT_WIDTH-1:0]   w_dt_nxt;
    logic [N_REQ-1:0]      w_src_nxt;

    always_comb begin
        w_time_nxt  = r_emu_time + TIME_WIDTH'(r_emu_dt);
        w_stop_hit  = (stop_time <= w_time_nxt);
        w_remaining = w_stop_hit ? '0 : (stop_time - w_time_nxt);
        w_limit     = (c_DT_MAX < w_remaining) ? c_DT_MAX : w_remaining;
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_best_req   = dt_req[DT_WIDTH-1:0];
        w_best_oh    = '0;
        w_best_oh[0] = 1'b1;
        for (int i = 1; i < N_REQ; i++) begin
            if (dt_req[i*DT_WIDTH +: DT_WIDTH] < w_best_req) begin
                w_best_req   = dt_req[i*DT_WIDTH +: DT_WIDTH];
                w_best_oh    = '0;
                w_best_oh[i] = 1'b1;
            end
        end
        w_req_wins = (TIME_WIDTH'(w_best_req) <= w_limit);
        w_cand     = w_req_wins ? w_best_req : w_limit[DT_WIDTH-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (run) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_stop_hit)         w_state_nxt = S_DONE;
                else if (stall || !run) w_state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_stop_hit)         w_state_nxt = S_DONE;
                else if (!stall && run) w_state_nxt = S_RUN;
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_dt_nxt  = '0;
        w_src_nxt = '0;
        if (w_state_nxt == S_RUN) begin
            w_dt_nxt  = w_cand;
            w_src_nxt = w_req_wins ? w_best_oh : '0;
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            r_state      <= S_IDLE;
            r_emu_dt     <= '0;
            r_emu_time   <= '0;
            r_dt_src     <= '0;
            r_step_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_emu_dt   <= w_dt_nxt;
            r_emu_time <= w_time_nxt;
            r_dt_src   <= w_src_nxt;
            if (w_dt_nxt != '0) r_step_count <= r_step_count + 32'd1;
        end
    end

    assign emu_dt     = r_emu_dt;
    assign emu_time   = r_emu_time;
    assign dt_src     = r_dt_src;
    assign state      = r_state;
    assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_dt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dt_arbiter
// Purpose  : Directed vector table plus hand sequences for dt_arbiter.
// Revision : 1.0
// ============================================================================
module tb_dt_arbiter;

    localparam int N_REQ      = 2;
    localparam int DT_WIDTH   = 25;
    localparam int TIME_WIDTH = 39;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      run;
    logic                      stall;
    logic [TIME_WIDTH-1:0]     stop_time;
    logic [N_REQ*DT_WIDTH-1:0] dt_req;
    logic [DT_WIDTH-1:0]       emu_dt;
    logic [TIME_WIDTH-1:0]     emu_time;
    logic [N_REQ-1:0]          dt_src;
    logic [1:0]                state;
    logic [31:0]               step_count;

    int n_checks = 0;
    int n_err    = 0;

    dt_arbiter #(
        .N_REQ      (N_REQ),
        .DT_WIDTH   (DT_WIDTH),
        .TIME_WIDTH (TIME_WIDTH)
    ) u_dut (
        .emu_clk    (clk),
        .emu_rst    (rst),
        .run        (run),
        .stall      (stall),
        .stop_time  (stop_time),
        .dt_req     (dt_req),
        .emu_dt     (emu_dt),
        .emu_time   (emu_time),
        .dt_src     (dt_src),
        .state      (state),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                  rst;
        logic                  run;
        logic                  stall;
        logic [TIME_WIDTH-1:0] stop;
        logic [DT_WIDTH-1:0]   req1;
        logic [DT_WIDTH-1:0]   req0;
        logic [1:0]            e_state;
        logic [DT_WIDTH-1:0]   e_dt;
        logic [TIME_WIDTH-1:0] e_time;
        logic [N_REQ-1:0]      e_src;
        logic [31:0]           e_step;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rn, input logic st,
                       input longint stop, input int q1, input int q0,
                       input int es, input int edt, input longint et,
                       input int esrc, input int estep);
        vec_t v;
        v.rst = r; v.run = rn; v.stall = st;
        v.stop = TIME_WIDTH'(stop);
        v.req1 = DT_WIDTH'(q1); v.req0 = DT_WIDTH'(q0);
        v.e_state = 2'(es); v.e_dt = DT_WIDTH'(edt);
        v.e_time = TIME_WIDTH'(et); v.e_src = N_REQ'(esrc);
        v.e_step = 32'(estep);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rn, input logic st,
                         input longint stop, input int q1, input int q0);
        rst       = r;
        run       = rn;
        stall     = st;
        stop_time = TIME_WIDTH'(stop);
        dt_req    = {DT_WIDTH'(q1), DT_WIDTH'(q0)};
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int es, input int edt,
                           input longint et, input int esrc, input int estep);
        chk({tag, " state"},      64'(state),      64'(es));
        chk({tag, " emu_dt"},     64'(emu_dt),     64'(edt));
        chk({tag, " emu_time"},   64'(emu_time),   64'(et));
        chk({tag, " dt_src"},     64'(dt_src),     64'(esrc));
        chk({tag, " step_count"}, 64'(step_count), 64'(estep));
    endtask

    localparam longint BIG_STOP = 64'h7F_FFFF_FFFF;
    localparam int     BIG_REQ  = 32'h1FF_FFFF;
    localparam int     DTMAX    = 16777215;

    initial begin
        rst = 1'b1; run = 1'b0; stall = 1'b0; stop_time = '0; dt_req = '0;

        //  rst run stl stop      req1  req0   state dt     time      src step
        add(1, 0, 0, 1000,     30,   20,    0,  0,     0,        0, 0);
        add(0, 1, 0, 1000,     30,   20,    1,  20,    0,        1, 1);
        add(0, 1, 0, 1000,     30,   20,    1,  20,    20,       1, 2);
        add(0, 1, 0, 1000,     40,   40,    1,  40,    40,       1, 3);
        add(0, 1, 0, 1000,     0,    50,    1,  0,     80,       2, 3);
        add(0, 1, 0, 1000,     0,    50,    1,  0,     80,       2, 3);
        add(0, 1, 1, 1000,     30,   20,    2,  0,     80,       0, 3);
        add(0, 1, 1, 1000,     30,   20,    2,  0,     80,       0, 3);
        add(0, 1, 1, 1000,     30,   20,    2,  0,     80,       0, 3);
        add(0, 1, 0, 1000,     30,   20,    1,  20,    80,       1, 4);
        add(0, 0, 0, 1000,     30,   20,    2,  0,     100,      0, 4);
        add(0, 1, 0, 1000,     30,   20,    1,  20,    100,      1, 5);
        add(0, 1, 0, 1000,     30,   20,    1,  20,    120,      1, 6);
        add(0, 1, 0, 1000,     300,  260,   1,  260,   140,      1, 7);
        add(0, 1, 0, 1000,     300,  300,   1,  300,   400,      1, 8);
        add(1, 1, 0, 1000,     300,  300,   0,  0,     0,        0, 0);
        add(0, 0, 0, 1000,     300,  300,   0,  0,     0,        0, 0);
        add(0, 1, 0, 250,      100,  100,   1,  100,   0,        1, 1);
        add(0, 1, 0, 250,      100,  100,   1,  100,   100,      1, 2);
        add(0, 1, 0, 250,      100,  100,   1,  50,    200,      0, 3);
        add(0, 1, 0, 250,      100,  100,   3,  0,     250,      0, 3);
        add(0, 1, 0, 250,      100,  100,   3,  0,     250,      0, 3);
        add(0, 1, 0, 1000,     100,  100,   3,  0,     250,      0, 3);
        add(1, 0, 0, BIG_STOP, BIG_REQ, BIG_REQ, 0, 0,  0,        0, 0);
        add(0, 1, 0, BIG_STOP, BIG_REQ, BIG_REQ, 1, DTMAX, 0,     0, 1);
        add(0, 1, 0, BIG_STOP, BIG_REQ, BIG_REQ, 1, DTMAX, DTMAX, 0, 2);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].run, vecs[i].stall, longint'(vecs[i].stop),
                  int'(vecs[i].req1), int'(vecs[i].req0));
            chk_all($sformatf("row%0d", i), int'(vecs[i].e_state), int'(vecs[i].e_dt),
                    longint'(vecs[i].e_time), int'(vecs[i].e_src), int'(vecs[i].e_step));
        end

        // Stall arriving on the same edge as the stop condition must yield DONE.
        drive(1, 0, 0, 30, 50, 10);
        drive(0, 1, 0, 30, 50, 10);
        drive(0, 1, 0, 30, 50, 10);
        drive(0, 1, 0, 30, 50, 10);
        chk_all("prio_eq_remaining", 1, 10, 20, 1, 3);
        drive(0, 1, 1, 30, 50, 10);
        chk_all("prio_stall_done", 3, 0, 30, 0, 3);

        // Lowering stop_time below the next time while paused terminates.
        drive(1, 0, 0, 1000, 20, 20);
        drive(0, 1, 0, 1000, 20, 20);
        chk_all("pause_run", 1, 20, 0, 1, 1);
        drive(0, 1, 1, 1000, 20, 20);
        chk_all("pause_enter", 2, 0, 20, 0, 1);
        drive(0, 1, 1, 10, 20, 20);
        chk_all("pause_stop_low", 3, 0, 20, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
